sram_arb_ctrl: RTL and testbench

Synchronous controller and two-port arbiter for the external HM65256BLSP 32Kx8 asynchronous SRAM on the DE0 board. Two on-chip requesters (port A, port B) issue single-byte read/write requests with a req/ack handshake. The block arbitrates between them, sequences CE_n/OE_n/WE_n with programmable wait states, and drives and tristates the shared data bus. Writes commit on the rising edge of WE_n, as the part's datasheet requires.

---
 rtl/sram_arb_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_sram_arb_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arb_ctrl.sv
// Two-port round-robin arbiter and strobe sequencer for an external async 32Kx8 SRAM.
// Define SRAM_ARB_FIXED_PRIO_EN for fixed priority (port A always wins a tie).
module sram_arb_ctrl #(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 8,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_dq,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    generate
        if (WAIT_CYC < 1 || WAIT_CYC > 15) begin : g_bad_wait
            $error("sram_arb_ctrl: WAIT_CYC must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        HOLD    = 3'd3,
        RECOVER = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              gnt_q, gnt_d;    // 1 = port B owns the current access
    logic              last_q, last_d;  // 1 = port B was granted last
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0] dq_out_q, dq_out_d;
    logic              dq_oe_q, dq_oe_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              a_ack_q, a_ack_d;
    logic              b_ack_q, b_ack_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
    logic              sel_b;

    // Strobe outputs are computed for the state being entered, so every pin is a flop.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        wr_d        = wr_q;
        sram_addr_d = sram_addr_q;
        dq_out_d    = dq_out_q;
        a_rdata_d   = a_rdata_q;
        b_rdata_d   = b_rdata_q;
        a_ack_d     = 1'b0;
        b_ack_d     = 1'b0;
        ce_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        we_n_d      = 1'b1;
        dq_oe_d     = 1'b0;
        sel_b       = 1'b0;

        case (state_q)
            IDLE: begin
                if (a_req || b_req) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
                    sel_b = !a_req;
`else
                    sel_b = b_req && (!a_req || !last_q);
`endif
                    gnt_d       = sel_b;
                    wr_d        = sel_b ? b_we    : a_we;
                    sram_addr_d = sel_b ? b_addr  : a_addr;
                    dq_out_d    = sel_b ? b_wdata : a_wdata;
                    ce_n_d      = 1'b0;
                    dq_oe_d     = wr_d;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                ce_n_d  = 1'b0;
                oe_n_d  = wr_q;
                we_n_d  = !wr_q;
                dq_oe_d = wr_q;
                cnt_d   = CNT_LOAD;
                state_d = STROBE;
            end
            STROBE: begin
                ce_n_d  = 1'b0;
                dq_oe_d = wr_q;
                if (cnt_q == 4'd0) begin
                    if (!wr_q) begin
                        if (gnt_q) b_rdata_d = sram_dq;
                        else       a_rdata_d = sram_dq;
                    end
                    a_ack_d = !gnt_q;
                    b_ack_d = gnt_q;
                    state_d = HOLD;
                end else begin
                    cnt_d  = cnt_q - 4'd1;
                    oe_n_d = wr_q;
                    we_n_d = !wr_q;
                end
            end
            HOLD: begin
                state_d = RECOVER;
            end
            RECOVER: begin
                last_d  = gnt_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            gnt_q       <= 1'b0;
            last_q      <= 1'b1;
            wr_q        <= 1'b0;
            sram_addr_q <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            a_ack_q     <= 1'b0;
            b_ack_q     <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            wr_q        <= wr_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            a_ack_q     <= a_ack_d;
            b_ack_q     <= b_ack_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
        end
    end

    assign sram_dq   = dq_oe_q ? dq_out_q : {DATA_W{1'bz}};
    assign sram_addr = sram_addr_q;
    assign sram_ce_n = ce_n_q;
    assign sram_oe_n = oe_n_q;
    assign sram_we_n = we_n_q;
    assign a_ack     = a_ack_q;
    assign b_ack     = b_ack_q;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Bench for sram_arb_ctrl: queued requests per port, async SRAM device model,
// arbitration-order / latency / strobe-width reference model.
module tb_sram_arb_ctrl;

    localparam int W = 2;

    typedef struct {
        logic        we;
        logic [14:0] addr;
        logic [7:0]  wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [14:0] a_addr = '0, b_addr = '0;
    logic [7:0]  a_wdata = '0, b_wdata = '0;
    logic        a_ack, b_ack, busy;
    logic [7:0]  a_rdata, b_rdata;
    logic [14:0] sram_addr;
    wire  [7:0]  sram_dq;
    logic        sram_ce_n, sram_oe_n, sram_we_n;

    sram_arb_ctrl #(.ADDR_W(15), .DATA_W(8), .WAIT_CYC(W)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .busy(busy), .sram_addr(sram_addr), .sram_dq(sram_dq),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Asynchronous SRAM device: drives on CE&OE with WE high, commits on WE_n rising.
    logic [7:0] dev_mem [0:32767];
    assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? dev_mem[sram_addr] : 8'hzz;
    always @(posedge sram_we_n) if (!sram_ce_n && !rst) dev_mem[sram_addr] <= sram_dq;

    int          n_tests = 0;
    int          n_fail  = 0;
    txn_t        qa[$];
    txn_t        qb[$];
    logic [7:0]  ref_mem [int];
    logic [7:0]  exp_a_rd = 8'h00, exp_b_rd = 8'h00;
    logic        last_b = 1'b1;
    logic        cur_b = 1'b0, cur_valid = 1'b0;
    int          we_run = 0, oe_run = 0;
    logic [14:0] pool [8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic pick(input logic ra, input logic rb, input logic lb);
`ifdef SRAM_ARB_FIXED_PRIO_EN
        return !ra;
`else
        if (ra && rb) return !lb;
        return rb;
`endif
    endfunction

    task automatic drive_ports();
        a_req = (qa.size() != 0);
        b_req = (qb.size() != 0);
        if (qa.size() != 0) begin a_we = qa[0].we; a_addr = qa[0].addr; a_wdata = qa[0].wdata; end
        if (qb.size() != 0) begin b_we = qb[0].we; b_addr = qb[0].addr; b_wdata = qb[0].wdata; end
    endtask

    task automatic scramble(input logic port_b);
        if (port_b) begin b_we = 1'($urandom); b_addr = 15'($urandom); b_wdata = 8'($urandom); end
        else        begin a_we = 1'($urandom); a_addr = 15'($urandom); a_wdata = 8'($urandom); end
    endtask

    task automatic push(input logic port_b, input logic we, input logic [14:0] addr, input logic [7:0] d);
        txn_t t;
        t.we = we; t.addr = addr; t.wdata = d;
        if (port_b) qb.push_back(t); else qa.push_back(t);
    endtask

    // Per-cycle bus rules, sampled just after the rising edge.
    task automatic mon();
        txn_t h;
        if (rst) begin
            we_run = 0; oe_run = 0;
            return;
        end
        check("oe_we_excl", {31'd0, sram_oe_n | sram_we_n}, 1);
        if (!sram_we_n) we_run++;
        else if (we_run != 0) begin check("we_width", we_run, W); we_run = 0; end
        if (!sram_oe_n) oe_run++;
        else if (oe_run != 0) begin check("oe_width", oe_run, W); oe_run = 0; end
        if (cur_valid && !sram_ce_n && (cur_b ? qb.size() : qa.size()) != 0) begin
            h = cur_b ? qb[0] : qa[0];
            check("bus_addr", {17'd0, sram_addr}, {17'd0, h.addr});
            if (h.we) check("wr_oe_high", {31'd0, sram_oe_n}, 1);
            else      check("rd_we_high", {31'd0, sram_we_n}, 1);
            if (h.we && !sram_we_n) check("wr_dq", {24'd0, sram_dq}, {24'd0, h.wdata});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        mon();
        @(negedge clk);
    endtask

    task automatic recover_reset();
        qa.delete(); qb.delete(); drive_ports();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        last_b = 1'b1; exp_a_rd = 8'h00; exp_b_rd = 8'h00; cur_valid = 1'b0;
    endtask

    task automatic run_batch();
        int   t_prev, exp_lat, n;
        logic first, eb;
        txn_t h;
        drive_ports();
        t_prev = cyc; exp_lat = W + 2; first = 1'b1;
        while (qa.size() + qb.size() > 0) begin
            eb = pick(qa.size() != 0, qb.size() != 0, last_b);
            cur_b = eb; cur_valid = 1'b1;
            repeat (first ? 1 : 2) tick();
            scramble(eb);
            first = 1'b0;
            n = 0;
            while (!(a_ack || b_ack) && n < W + 12) begin tick(); n++; end
            check("ack_port", {30'd0, a_ack, b_ack}, eb ? 32'd1 : 32'd2);
            if (!(a_ack || b_ack)) begin
                recover_reset();
                return;
            end
            check("ack_latency", cyc - t_prev, exp_lat);
            t_prev = cyc; exp_lat = W + 4;
            h = eb ? qb[0] : qa[0];
            check("hold_strobes", {29'd0, sram_ce_n, sram_oe_n, sram_we_n}, 3'b011);
            if (h.we) begin
                check("hold_dq", {24'd0, sram_dq}, {24'd0, h.wdata});
                ref_mem[int'(h.addr)] = h.wdata;
            end else if (ref_mem.exists(int'(h.addr))) begin
                if (eb) exp_b_rd = ref_mem[int'(h.addr)];
                else    exp_a_rd = ref_mem[int'(h.addr)];
            end
            check("a_rdata", {24'd0, a_rdata}, {24'd0, exp_a_rd});
            check("b_rdata", {24'd0, b_rdata}, {24'd0, exp_b_rd});
            if (eb) void'(qb.pop_front()); else void'(qa.pop_front());
            last_b = eb;
            drive_ports();
            tick();
            check("recover", {29'd0, a_ack, b_ack, sram_ce_n}, 3'b001);
        end
        cur_valid = 1'b0;
        tick(); tick();
        check("idle_busy", {31'd0, busy}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) tick();
        check("rst_strobes", {29'd0, sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
        check("rst_addr", {17'd0, sram_addr}, 0);
        check("rst_ack_busy", {29'd0, a_ack, b_ack, busy}, 0);
        check("rst_rdata", {16'd0, a_rdata, b_rdata}, 0);
        rst = 1'b0;
        tick();

        push(0, 1, 15'h1234, 8'h5A);                 run_batch();
        push(0, 0, 15'h1234, 8'h00);                 run_batch();
        push(0, 1, 15'h0001, 8'h11); push(0, 0, 15'h0002, 8'h00);
        push(1, 1, 15'h0002, 8'h22); push(1, 0, 15'h0001, 8'h00);
        run_batch();
        push(0, 1, 15'h7FFF, 8'hA5); push(1, 1, 15'h0000, 8'h3C);
        push(0, 0, 15'h0000, 8'h00); push(1, 0, 15'h7FFF, 8'h00);
        run_batch();

        // Reset in the middle of a read strobe.
        push(0, 0, 15'h1234, 8'h00);
        drive_ports();
        cur_b = 1'b0; cur_valid = 1'b1;
        n = 0;
        while (sram_oe_n && n < 20) begin tick(); n++; end
        check("rst_strobe_seen", {31'd0, sram_oe_n}, 0);
        rst = 1'b1;
        qa.delete(); drive_ports();
        tick();
        check("rst_abort", {26'd0, sram_ce_n, sram_oe_n, sram_we_n, a_ack, b_ack, busy}, 6'b111000);
        rst = 1'b0; cur_valid = 1'b0; last_b = 1'b1; exp_a_rd = 8'h00; exp_b_rd = 8'h00;
        check("rst_rdata_clr", {24'd0, a_rdata}, 0);
        repeat (3) begin
            tick();
            check("rst_no_ack", {30'd0, a_ack, b_ack}, 0);
        end
        push(1, 0, 15'h1234, 8'h00);                 run_batch();

        // Contention with unequal queue depths.
        for (int i = 0; i < 3; i++) push(0, 1, 15'(16'h0100 + i), 8'(8'h40 + i));
        for (int i = 0; i < 2; i++) push(1, 0, 15'(16'h0100 + i), 8'h00);
        run_batch();

        pool[0] = 15'h0000; pool[1] = 15'h7FFF; pool[2] = 15'h1234; pool[3] = 15'h4000;
        for (int i = 4; i < 8; i++) pool[i] = 15'($urandom);
        for (int i = 0; i < 8; i++) push(0, 1, pool[i], 8'($urandom));
        run_batch();

        for (int bt = 0; bt < 30; bt++) begin
            int na, nb;
            na = $urandom_range(0, 3);
            nb = $urandom_range(0, 3);
            if (na + nb == 0) na = 1;
            for (int i = 0; i < na; i++) push(0, 1'($urandom), pool[$urandom_range(0, 7)], 8'($urandom));
            for (int i = 0; i < nb; i++) push(1, 1'($urandom), pool[$urandom_range(0, 7)], 8'($urandom));
            repeat ($urandom_range(0, 3)) tick();
            run_batch();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
